soc_system_response_fifo: RTL and testbench
===========================================

Name: soc_system_response_fifo

Overview:
- Avalon-MM slave carrying FPGA-to-HPS traffic: printer-control logic pushes 32-bit response/status words through a valid/ready port; HPS software pops them through a register window.
- Return path for the HPS-written command output register; same Avalon slave conventions (2-bit word address, chipselect, active-low strobes, zero read latency, no waitrequest).
- Provides level/flag status, sticky error flags, flush, and a level-sensitive interrupt.

Parameters:
- DATA_WIDTH, 32, width of pushed words and of readdata/writedata; must be 32.
- DEPTH, 16, FIFO entries; power of two, 2..256.
- AW, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- read_n  in  1  Avalon read strobe, active low
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational, zero latency
- in_data  in  32  response word from printer logic
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; equals ~full
- irq  out  1  interrupt to HPS, active high, level

Behaviour:
- Single clock domain. reset_n low asynchronously clears wr_ptr, rd_ptr, level, ovf, udf, and irq_en. Storage RAM is not cleared. Resulting outputs: in_ready=1, irq=0, readdata=0 except STATUS (empty=1).
- rd_cs = chipselect & ~read_n. wr_cs = chipselect & ~write_n. Each read or write strobe lasts exactly one clk cycle.
- Register map:
  - addr 0 DATA (R): readdata = head word when non-empty, 0 when empty. On the rd_cs edge, pops when non-empty; when empty, sets udf and leaves pointers unchanged. Writes are ignored.
  - addr 1 STATUS (R/W1C): [AW:0] level 0..DEPTH, [16] empty, [17] full, [18] ovf, [19] udf, other bits 0. Writing 1 to bit 18 clears ovf; writing 1 to bit 19 clears udf. Writing 0 has no effect.
  - addr 2 CONTROL (R/W): [0] irq_en (reset 0). Bit [1] flush is write-only and self-clearing (reads 0); writing 1 empties the FIFO in that edge (pointers and level to 0). Other bits read 0.
  - addr 3: reads 0; writes ignored.
- Push: occurs at the edge where in_valid & in_ready. in_ready is combinational ~full.
- in_valid while full: no push, ovf set (sticky). Handshake keeps data safe; ovf flags producer stall for software diagnosis.
- Simultaneous push and pop when non-empty and non-full: both occur, level unchanged, order preserved.
- Simultaneous push and pop when empty: pop returns 0 and sets udf; push completes; level becomes 1.
- Simultaneous push and pop when full: in_ready=0, so no push (ovf set if in_valid); pop occurs; level = DEPTH-1.
- Flush priority: flush beats a concurrent push and pop in the same edge; the pushed word is discarded and level becomes 0. A flush write on the same edge as a W1C to STATUS is impossible, since there is a single port.
- Sticky flag priority: a set event and a W1C clear on the same edge leave the flag set.
- Pointers wrap modulo DEPTH. Level is tracked as a separate AW+1-bit counter: full = (level==DEPTH), empty = (level==0).
- irq = irq_en & ~empty, driven from registers with no combinational path from Avalon inputs. irq deasserts the cycle after the last word is popped.
- Reset asserted mid-transfer discards all contents. in_ready is 1 immediately on reset assertion.

Test Plan:
- Reset: read STATUS -> 0x0001_0000 (empty=1, level 0); read DATA -> 0, then STATUS -> 0x0009_0000 (udf set); write STATUS 0x0008_0000 -> reads 0x0001_0000.
- Push 0x11, 0x22, 0x33, then read DATA three times -> 0x11, 0x22, 0x33 in order; STATUS level goes 3→2→1→0.
- Push 16 words (DEPTH=16) -> STATUS 0x0002_0010, in_ready=0; hold in_valid 2 more cycles -> ovf=1, level stays 16, 17th word not stored; pop once -> in_ready=1.
- Write CONTROL=1 with FIFO empty -> irq=0; push one word -> irq=1 the next cycle; pop -> irq=0; write CONTROL=0 with data present -> irq=0.
- With level 5, push and pop on the same edge -> level 5, popped value equals oldest word. With level 0, push and pop on the same edge -> readdata 0, udf=1, level 1.
- With level 7, write CONTROL=2 on the same edge as a push -> level 0, empty=1, CONTROL reads 0 for flush bit; assert reset_n low mid-push stream -> in_ready=1, level 0, irq_en 0.

Source files
------------

// File: rtl/soc_system_response_fifo.sv
// Avalon-MM response FIFO: printer logic pushes 32-bit words over valid/ready,
// HPS pops them through a 4-word register window with status, flush and irq.
module soc_system_response_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level;
  logic                  ovf, udf, irq_en;

  logic rd_cs, wr_cs, empty, full, push, pop, flush;
  logic ovf_clr, udf_clr, ctrl_wr, ovf_set, udf_set;
  logic [DATA_WIDTH-1:0] status;
  logic unused_wdata;

  assign rd_cs = chipselect & ~read_n;
  assign wr_cs = chipselect & ~write_n;

  assign empty    = (level == '0);
  assign full     = (level == FULL_LEVEL);
  assign in_ready = ~full;

  assign push    = in_valid & ~full;
  assign pop     = rd_cs & (address == 2'd0) & ~empty;
  assign udf_set = rd_cs & (address == 2'd0) & empty;
  assign ovf_set = in_valid & full;

  assign ctrl_wr = wr_cs & (address == 2'd2);
  assign flush   = ctrl_wr & writedata[1];
  assign ovf_clr = wr_cs & (address == 2'd1) & writedata[18];
  assign udf_clr = wr_cs & (address == 2'd1) & writedata[19];

  assign irq = irq_en & ~empty;

  assign unused_wdata = ^{writedata[DATA_WIDTH-1:20], writedata[17:2]};

  // Storage is intentionally not reset; only pointers/level define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Flush overrides any concurrent push/pop; sticky set wins over W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      level <= level + LVL_ONE;
        else if (pop && !push) level <= level - LVL_ONE;
      end
      ovf <= ovf_set | (ovf & ~ovf_clr);
      udf <= udf_set | (udf & ~udf_clr);
      if (ctrl_wr) irq_en <= writedata[0];
    end
  end

  always_comb begin
    status       = '0;
    status[AW:0] = level;
    status[16]   = empty;
    status[17]   = full;
    status[18]   = ovf;
    status[19]   = udf;
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    if (!empty) readdata = mem[rd_ptr];
      2'd1:    readdata = status;
      2'd2:    readdata[0] = irq_en;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_response_fifo.sv
// Self-checking bench for soc_system_response_fifo: directed steps followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_soc_system_response_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        irq;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] q[$];
  bit          mOvf, mUdf, mIrqEn;

  soc_system_response_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      2'd0: r = (q.size() > 0) ? q[0] : 32'h0;
      2'd1: r = 32'(q.size()) + ((q.size() == 0) ? 32'h0001_0000 : 32'h0)
              + ((q.size() == DEPTH) ? 32'h0002_0000 : 32'h0)
              + (mOvf ? 32'h0004_0000 : 32'h0) + (mUdf ? 32'h0008_0000 : 32'h0);
      2'd2: r = mIrqEn ? 32'h1 : 32'h0;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic void modelReset();
    q.delete();
    mOvf = 0; mUdf = 0; mIrqEn = 0;
  endfunction

  function automatic void modelEdge(input logic [1:0] a, input logic cs, input logic rdn,
                                    input logic wrn, input logic [31:0] wd,
                                    input logic v, input logic [31:0] d);
    bit rd, wr, wasFull, ovfSet, udfSet;
    rd = cs && !rdn;
    wr = cs && !wrn;
    wasFull = (q.size() == DEPTH);
    ovfSet = v && wasFull;
    udfSet = 0;
    if (rd && a == 2'd0) begin
      if (q.size() > 0) void'(q.pop_front());
      else udfSet = 1;
    end
    if (v && !wasFull) q.push_back(d);
    if (wr && a == 2'd2) begin
      mIrqEn = wd[0];
      if (wd[1]) q.delete();
    end
    mOvf = ovfSet || (mOvf && !(wr && a == 2'd1 && wd[18]));
    mUdf = udfSet || (mUdf && !(wr && a == 2'd1 && wd[19]));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkPorts(input string tag);
    checkOutput({tag, ".in_ready"}, {31'b0, in_ready}, 32'(q.size() < DEPTH));
    checkOutput({tag, ".irq"}, {31'b0, irq}, 32'(mIrqEn && q.size() > 0));
  endtask

  // Drives one cycle of inputs, checks outputs before the edge, then advances the model.
  task automatic applyStimulus(input string tag, input logic [1:0] a, input logic cs,
                               input logic rdn, input logic wrn, input logic [31:0] wd,
                               input logic v, input logic [31:0] d,
                               input bit hasConst, input logic [31:0] constExp);
    address = a; chipselect = cs; read_n = rdn; write_n = wrn;
    writedata = wd; in_valid = v; in_data = d;
    #1;
    if (cs && !rdn) begin
      checkOutput({tag, ".rdata"}, readdata, modelRead(a));
      if (hasConst) checkOutput({tag, ".const"}, readdata, constExp);
    end
    checkPorts(tag);
    @(posedge clk);
    modelEdge(a, cs, rdn, wrn, wd, v, d);
    #1;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic pushWord(input string tag, input logic [31:0] d);
    applyStimulus(tag, 2'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, d, 1'b0, 32'h0);
  endtask

  task automatic readReg(input string tag, input logic [1:0] a);
    applyStimulus(tag, a, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic readExpect(input string tag, input logic [1:0] a, input logic [31:0] exp);
    applyStimulus(tag, a, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, exp);
  endtask

  task automatic writeReg(input string tag, input logic [1:0] a, input logic [31:0] wd,
                          input logic v, input logic [31:0] d);
    applyStimulus(tag, a, 1'b1, 1'b1, 1'b0, wd, v, d, 1'b0, 32'h0);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 2'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  int          op;
  logic        rv;
  logic [31:0] rd32, rw32;

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state and underflow flag
    checkPorts("rst");
    readExpect("rst.status", 2'd1, 32'h0001_0000);
    readExpect("rst.data", 2'd0, 32'h0);
    readExpect("udf.status", 2'd1, 32'h0009_0000);
    writeReg("udf.w1c", 2'd1, 32'h0008_0000, 1'b0, 32'h0);
    readExpect("udf.cleared", 2'd1, 32'h0001_0000);

    // Ordering
    pushWord("ord.p0", 32'h11);
    pushWord("ord.p1", 32'h22);
    pushWord("ord.p2", 32'h33);
    readExpect("ord.lvl3", 2'd1, 32'h0000_0003);
    readExpect("ord.d0", 2'd0, 32'h11);
    readExpect("ord.lvl2", 2'd1, 32'h0000_0002);
    readExpect("ord.d1", 2'd0, 32'h22);
    readExpect("ord.lvl1", 2'd1, 32'h0000_0001);
    readExpect("ord.d2", 2'd0, 32'h33);
    readExpect("ord.lvl0", 2'd1, 32'h0001_0000);

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) pushWord("fill.push", 32'hA000_0000 + 32'(i));
    readExpect("fill.status", 2'd1, 32'h0002_0010);
    pushWord("fill.ovf0", 32'hDEAD_0001);
    pushWord("fill.ovf1", 32'hDEAD_0002);
    readExpect("fill.ovf", 2'd1, 32'h0006_0010);
    readExpect("fill.pop", 2'd0, 32'hA000_0000);
    checkOutput("fill.ready_after_pop", {31'b0, in_ready}, 32'h1);
    for (int i = 1; i < DEPTH; i++) readReg("fill.drain", 2'd0);
    readReg("fill.empty_pop", 2'd0);
    writeReg("fill.w1c", 2'd1, 32'h000C_0000, 1'b0, 32'h0);
    readExpect("fill.cleared", 2'd1, 32'h0001_0000);

    // Interrupt
    writeReg("irq.en", 2'd2, 32'h1, 1'b0, 32'h0);
    checkOutput("irq.empty", {31'b0, irq}, 32'h0);
    pushWord("irq.push", 32'h5555_AAAA);
    checkOutput("irq.set", {31'b0, irq}, 32'h1);
    readReg("irq.pop", 2'd0);
    checkOutput("irq.clear", {31'b0, irq}, 32'h0);
    pushWord("irq.push2", 32'h1234_5678);
    writeReg("irq.dis", 2'd2, 32'h0, 1'b0, 32'h0);
    checkOutput("irq.disabled", {31'b0, irq}, 32'h0);
    readReg("irq.drain", 2'd0);

    // Simultaneous push/pop at level 5 and at empty
    for (int i = 0; i < 5; i++) pushWord("sim.push", 32'h500 + 32'(i));
    applyStimulus("sim.l5", 2'd0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h505, 1'b1, 32'h500);
    readExpect("sim.l5lvl", 2'd1, 32'h0000_0005);
    for (int i = 0; i < 5; i++) readReg("sim.drain", 2'd0);
    applyStimulus("sim.l0", 2'd0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h600, 1'b1, 32'h0);
    readExpect("sim.l0lvl", 2'd1, 32'h0008_0001);
    writeReg("sim.w1c", 2'd1, 32'h0008_0000, 1'b0, 32'h0);
    readExpect("sim.l0data", 2'd0, 32'h600);

    // Flush beats concurrent push
    for (int i = 0; i < 7; i++) pushWord("fl.push", 32'h700 + 32'(i));
    writeReg("fl.flush", 2'd2, 32'h2, 1'b1, 32'h7FF);
    readExpect("fl.status", 2'd1, 32'h0001_0000);
    readExpect("fl.ctrl", 2'd2, 32'h0);

    // Reset mid push stream
    writeReg("mr.en", 2'd2, 32'h1, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) pushWord("mr.push", 32'h800 + 32'(i));
    in_valid = 1'b1; in_data = 32'h8FF;
    #2 reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("mr.ready", {31'b0, in_ready}, 32'h1);
    checkOutput("mr.irq", {31'b0, irq}, 32'h0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    readExpect("mr.status", 2'd1, 32'h0001_0000);
    readExpect("mr.ctrl", 2'd2, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      op   = int'($urandom_range(0, 15));
      rv   = ($urandom_range(0, 3) < ((i < 200) ? 3 : 1));
      rd32 = $urandom;
      rw32 = $urandom;
      case (op)
        0, 1, 2, 3, 4, 5: applyStimulus("rnd.data", 2'd0, 1'b1, 1'b0, 1'b1, 32'h0, rv, rd32, 1'b0, 32'h0);
        6, 7:  applyStimulus("rnd.status", 2'd1, 1'b1, 1'b0, 1'b1, 32'h0, rv, rd32, 1'b0, 32'h0);
        8:     writeReg("rnd.w1c", 2'd1, rw32, rv, rd32);
        9:     writeReg("rnd.ctrl", 2'd2, ($urandom_range(0, 3) == 0) ? rw32 : (rw32 & ~32'h2), rv, rd32);
        10:    applyStimulus("rnd.rctrl", 2'd2, 1'b1, 1'b0, 1'b1, 32'h0, rv, rd32, 1'b0, 32'h0);
        11:    applyStimulus("rnd.r3", 2'd3, 1'b1, 1'b0, 1'b1, 32'h0, rv, rd32, 1'b0, 32'h0);
        12:    writeReg("rnd.wign", ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, rw32, rv, rd32);
        default: applyStimulus("rnd.idle", 2'd0, 1'b0, 1'b1, 1'b1, 32'h0, rv, rd32, 1'b0, 32'h0);
      endcase
    end
    readReg("rnd.final", 2'd1);
    idleCycle("end");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
